// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I decoder feeding a three-stage ID/EX, EX/MEM, MEM/WB control pipeline.
// Optional M-extension decode enabled by defining CTRL_MEXT_EN.
module pipelined_control_unit #(
    parameter int ALU_W  = 5,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_d,
    input  logic              valid_d,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [ALU_W-1:0]  ex_alu_ctrl,
    output logic              ex_alu_src,
    output logic [IMM_W-1:0]  ex_imm_src,
    output logic              ex_branch,
    output logic [2:0]        ex_branch_cond,
    output logic              ex_jump_imm,
    output logic              ex_jump_result,
    output logic              ex_pc_operand,
    output logic              ex_illegal,
    output logic              mem_write,
    output logic [1:0]        mem_byte_sel,
    output logic              mem_extend,
    output logic              wb_reg_write,
    output logic              wb_result_src,
    output logic              wb_write_next_pc,
    output logic [REG_AW-1:0] wb_rd
);

    typedef struct packed {
        logic              regWrite;
        logic              resultSrc;
        logic              writeNextPc;
        logic [REG_AW-1:0] rd;
    } wbCtrl_t;

    typedef struct packed {
        logic       memWrite;
        logic [1:0] memByteSel;
        logic       memExtend;
        wbCtrl_t    wb;
    } memCtrl_t;

    typedef struct packed {
        logic             valid;
        logic [ALU_W-1:0] aluCtrl;
        logic             aluSrc;
        logic [IMM_W-1:0] immSrc;
        logic             branch;
        logic [2:0]       branchCond;
        logic             jumpImm;
        logic             jumpResult;
        logic             pcOperand;
        logic             illegal;
        logic             memRead;
        memCtrl_t         mem;
    } exCtrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign rs1    = instr_d[19:15];
    assign rs2    = instr_d[24:20];
    assign funct7 = instr_d[31:25];

    function automatic logic [ALU_W-1:0] aluFromFunct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  aluFromFunct3 = alt ? ALU_W'(1) : ALU_W'(0);
            3'b001:  aluFromFunct3 = ALU_W'(2);
            3'b010:  aluFromFunct3 = ALU_W'(3);
            3'b011:  aluFromFunct3 = ALU_W'(4);
            3'b100:  aluFromFunct3 = ALU_W'(5);
            3'b101:  aluFromFunct3 = alt ? ALU_W'(7) : ALU_W'(6);
            3'b110:  aluFromFunct3 = ALU_W'(8);
            default: aluFromFunct3 = ALU_W'(9);
        endcase
    endfunction

    exCtrl_t  dec;
    exCtrl_t  idEx;
    memCtrl_t exMem;
    wbCtrl_t  memWb;
    logic     usesRs1;
    logic     usesRs2;
    logic     bad;
    logic     hazard;

    always_comb begin
        dec     = '0;
        usesRs1 = 1'b0;
        usesRs2 = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OP_R: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
                case (funct7)
                    7'b0000000: dec.aluCtrl = aluFromFunct3(funct3, 1'b0);
                    7'b0100000: begin
                        if (funct3 == 3'b000 || funct3 == 3'b101)
                            dec.aluCtrl = aluFromFunct3(funct3, 1'b1);
                        else
                            bad = 1'b1;
                    end
`ifdef CTRL_MEXT_EN
                    7'b0000001: dec.aluCtrl = ALU_W'(5'd16 + {2'b00, funct3});
`endif
                    default: bad = 1'b1;
                endcase
            end
            OP_IALU: begin
                usesRs1 = 1'b1;
                dec.aluSrc = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    bad = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    bad = 1'b1;
                dec.aluCtrl = aluFromFunct3(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OP_LOAD: begin
                usesRs1 = 1'b1;
                dec.aluSrc = 1'b1;
                dec.memRead = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
                dec.mem.wb.resultSrc = 1'b1;
                dec.mem.memExtend = ~funct3[2];
                dec.mem.memByteSel = (funct3[1:0] == 2'b00) ? 2'd2 :
                                     (funct3[1:0] == 2'b01) ? 2'd1 : 2'd0;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111 ||
                    (funct3 == 3'b100 && 1'b0))
                    bad = 1'b1;
            end
            OP_STORE: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                dec.aluSrc = 1'b1;
                dec.immSrc = IMM_W'(1);
                dec.mem.memWrite = 1'b1;
                dec.mem.memByteSel = (funct3[1:0] == 2'b00) ? 2'd2 :
                                     (funct3[1:0] == 2'b01) ? 2'd1 : 2'd0;
                if (funct3[2] || funct3[1:0] == 2'b11)
                    bad = 1'b1;
            end
            OP_BRANCH: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                dec.aluCtrl = ALU_W'(1);
                dec.immSrc = IMM_W'(2);
                dec.branch = 1'b1;
                dec.branchCond = funct3;
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    bad = 1'b1;
            end
            OP_JAL: begin
                dec.immSrc = IMM_W'(4);
                dec.jumpImm = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
                dec.mem.wb.writeNextPc = 1'b1;
            end
            OP_JALR: begin
                usesRs1 = 1'b1;
                dec.aluSrc = 1'b1;
                dec.jumpResult = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
                dec.mem.wb.writeNextPc = 1'b1;
                if (funct3 != 3'b000)
                    bad = 1'b1;
            end
            OP_LUI: begin
                dec.aluCtrl = ALU_W'(10);
                dec.aluSrc = 1'b1;
                dec.immSrc = IMM_W'(3);
                dec.mem.wb.regWrite = 1'b1;
            end
            OP_AUIPC: begin
                dec.aluSrc = 1'b1;
                dec.immSrc = IMM_W'(3);
                dec.pcOperand = 1'b1;
                dec.mem.wb.regWrite = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (dec.mem.wb.regWrite)
            dec.mem.wb.rd = REG_AW'(instr_d[11:7]);
        if (dec.mem.wb.rd == '0)
            dec.mem.wb.regWrite = 1'b0;

        // Undecodable encodings travel as a flagged no-op so EX can trap on them.
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            usesRs1     = 1'b0;
            usesRs2     = 1'b0;
        end

        dec.valid = 1'b1;
        if (!valid_d) begin
            dec     = '0;
            usesRs1 = 1'b0;
            usesRs2 = 1'b0;
        end
    end

    assign hazard = valid_d && idEx.valid && idEx.memRead && (idEx.mem.wb.rd != '0) &&
                    ((usesRs1 && REG_AW'(rs1) == idEx.mem.wb.rd) ||
                     (usesRs2 && REG_AW'(rs2) == idEx.mem.wb.rd));

    assign stall_o = hazard && !rst && !stall_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            idEx  <= '0;
            exMem <= '0;
            memWb <= '0;
        end else if (!stall_i) begin
            exMem <= idEx.mem;
            memWb <= exMem.wb;
            if (flush_i || hazard)
                idEx <= '0;
            else
                idEx <= dec;
        end
    end

    assign ex_valid         = idEx.valid;
    assign ex_alu_ctrl      = idEx.aluCtrl;
    assign ex_alu_src       = idEx.aluSrc;
    assign ex_imm_src       = idEx.immSrc;
    assign ex_branch        = idEx.branch;
    assign ex_branch_cond   = idEx.branchCond;
    assign ex_jump_imm      = idEx.jumpImm;
    assign ex_jump_result   = idEx.jumpResult;
    assign ex_pc_operand    = idEx.pcOperand;
    assign ex_illegal       = idEx.illegal;
    assign mem_write        = exMem.memWrite;
    assign mem_byte_sel     = exMem.memByteSel;
    assign mem_extend       = exMem.memExtend;
    assign wb_reg_write     = memWb.regWrite;
    assign wb_result_src    = memWb.resultSrc;
    assign wb_write_next_pc = memWb.writeNextPc;
    assign wb_rd            = memWb.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - directed checks of decode, hazard, stall, flush and reset behaviour.
module tb_pipelined_control_unit;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW    = 32'h0000A283;
    localparam logic [31:0] I_ADD65 = 32'h00528333;
    localparam logic [31:0] I_SW    = 32'h0020A223;
    localparam logic [31:0] I_ADDI7 = 32'h00500393;
    localparam logic [31:0] I_LUI   = 32'h12345537;
    localparam logic [31:0] I_JAL   = 32'h008000EF;
    localparam logic [31:0] I_BNE   = 32'h00209463;
    localparam logic [31:0] I_ADDX0 = 32'h00208033;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst, valid_d, stall_i, flush_i;
    logic [31:0] instr_d;
    logic        stall_o, ex_valid, ex_alu_src, ex_branch, ex_jump_imm, ex_jump_result;
    logic        ex_pc_operand, ex_illegal, mem_write, mem_extend;
    logic        wb_reg_write, wb_result_src, wb_write_next_pc;
    logic [4:0]  ex_alu_ctrl, wb_rd;
    logic [2:0]  ex_imm_src, ex_branch_cond;
    logic [1:0]  mem_byte_sel;

    int checks = 0;
    int errors = 0;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d),
        .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o),
        .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_alu_src(ex_alu_src),
        .ex_imm_src(ex_imm_src), .ex_branch(ex_branch), .ex_branch_cond(ex_branch_cond),
        .ex_jump_imm(ex_jump_imm), .ex_jump_result(ex_jump_result),
        .ex_pc_operand(ex_pc_operand), .ex_illegal(ex_illegal),
        .mem_write(mem_write), .mem_byte_sel(mem_byte_sel), .mem_extend(mem_extend),
        .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src),
        .wb_write_next_pc(wb_write_next_pc), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid_d = 1'b0; stall_i = 1'b0; flush_i = 1'b0; instr_d = '0;
        tick(); tick();
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_alu", 32'(ex_alu_ctrl), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_stall_o", 32'(stall_o), 0);
        rst = 1'b0;

        // add x3,x1,x2
        instr_d = I_ADD; valid_d = 1'b1;
        tick();
        chk("add_ex_valid", 32'(ex_valid), 1);
        chk("add_alu", 32'(ex_alu_ctrl), 0);
        chk("add_alu_src", 32'(ex_alu_src), 0);
        chk("add_illegal", 32'(ex_illegal), 0);
        valid_d = 1'b0;
        tick(); tick();
        chk("add_wb_reg_write", 32'(wb_reg_write), 1);
        chk("add_wb_rd", 32'(wb_rd), 3);
        chk("add_wb_result_src", 32'(wb_result_src), 0);
        chk("add_wb_next_pc", 32'(wb_write_next_pc), 0);

        // lw x5 followed by dependent add x6,x5,x5
        instr_d = I_LW; valid_d = 1'b1;
        tick();
        chk("lw_ex_alu_src", 32'(ex_alu_src), 1);
        instr_d = I_ADD65;
        #1;
        chk("lu_stall_o_hi", 32'(stall_o), 1);
        tick();
        chk("lu_bubble", 32'(ex_valid), 0);
        chk("lu_stall_o_lo", 32'(stall_o), 0);
        chk("lw_mem_byte_sel", 32'(mem_byte_sel), 0);
        chk("lw_mem_extend", 32'(mem_extend), 1);
        tick();
        chk("lu_add_ex_valid", 32'(ex_valid), 1);
        chk("lu_add_alu_src", 32'(ex_alu_src), 0);
        chk("lw_wb_result_src", 32'(wb_result_src), 1);
        chk("lw_wb_rd", 32'(wb_rd), 5);
        chk("lw_wb_reg_write", 32'(wb_reg_write), 1);
        valid_d = 1'b0;
        tick(); tick(); tick();

        // sw decode, then flush of a second sw
        instr_d = I_SW; valid_d = 1'b1;
        tick();
        chk("sw_imm_src", 32'(ex_imm_src), 1);
        chk("sw_alu_src", 32'(ex_alu_src), 1);
        instr_d = I_ADDI7;
        tick();
        chk("sw_mem_write", 32'(mem_write), 1);
        chk("sw_mem_byte_sel", 32'(mem_byte_sel), 0);
        instr_d = I_SW; flush_i = 1'b1;
        #1;
        chk("flush_stall_o", 32'(stall_o), 0);
        tick();
        chk("flush_ex_valid", 32'(ex_valid), 0);
        chk("flush_prior_mem_write", 32'(mem_write), 0);
        chk("sw_wb_reg_write", 32'(wb_reg_write), 0);
        flush_i = 1'b0; valid_d = 1'b0;
        tick();
        chk("flush_mem_write", 32'(mem_write), 0);
        chk("flush_prior_wb_rd", 32'(wb_rd), 7);
        chk("flush_prior_wb_we", 32'(wb_reg_write), 1);
        tick(); tick();

        // external stall with a load in EX and a dependent instruction in decode
        valid_d = 1'b1;
        instr_d = I_ADDI7; tick();
        instr_d = I_ADD;   tick();
        instr_d = I_LW;    tick();
        instr_d = I_ADD65; stall_i = 1'b1;
        #1;
        chk("stall_stall_o", 32'(stall_o), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ex_valid", 32'(ex_valid), 1);
            chk("stall_ex_alu_src", 32'(ex_alu_src), 1);
            chk("stall_wb_rd", 32'(wb_rd), 7);
            chk("stall_stall_o_hold", 32'(stall_o), 0);
        end
        stall_i = 1'b0;
        #1;
        chk("resume_stall_o", 32'(stall_o), 1);
        tick();
        chk("resume_bubble", 32'(ex_valid), 0);
        chk("resume_wb_rd", 32'(wb_rd), 3);
        tick();
        chk("resume_add_ex", 32'(ex_valid), 1);
        chk("resume_stall_o_lo", 32'(stall_o), 0);
        valid_d = 1'b0;
        tick(); tick(); tick();

        // lui, jal, bne, add x0
        valid_d = 1'b1;
        instr_d = I_LUI; tick();
        chk("lui_alu", 32'(ex_alu_ctrl), 10);
        chk("lui_imm_src", 32'(ex_imm_src), 3);
        chk("lui_alu_src", 32'(ex_alu_src), 1);
        instr_d = I_JAL; tick();
        chk("jal_jump_imm", 32'(ex_jump_imm), 1);
        chk("jal_imm_src", 32'(ex_imm_src), 4);
        instr_d = I_BNE; tick();
        chk("bne_branch", 32'(ex_branch), 1);
        chk("bne_cond", 32'(ex_branch_cond), 1);
        chk("bne_alu", 32'(ex_alu_ctrl), 1);
        chk("lui_wb_rd", 32'(wb_rd), 10);
        instr_d = I_ADDX0; tick();
        chk("jal_wb_next_pc", 32'(wb_write_next_pc), 1);
        chk("jal_wb_rd", 32'(wb_rd), 1);
        instr_d = I_BAD; tick();
        chk("bad_illegal", 32'(ex_illegal), 1);
        chk("bad_valid", 32'(ex_valid), 1);
        valid_d = 1'b0;
        tick();
        chk("x0_wb_reg_write", 32'(wb_reg_write), 0);
        tick();
        chk("bad_wb_reg_write", 32'(wb_reg_write), 0);
        tick();

        // reset with three live entries
        valid_d = 1'b1;
        instr_d = I_ADDI7; tick();
        instr_d = I_SW;    tick();
        instr_d = I_LUI;   tick();
        chk("pre_rst_mem_write", 32'(mem_write), 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ex_valid", 32'(ex_valid), 0);
        chk("mid_rst_alu", 32'(ex_alu_ctrl), 0);
        chk("mid_rst_mem_write", 32'(mem_write), 0);
        chk("mid_rst_wb_we", 32'(wb_reg_write), 0);
        chk("mid_rst_wb_rd", 32'(wb_rd), 0);
        rst = 1'b0;
        instr_d = I_ADD; tick();
        valid_d = 1'b0;
        tick(); tick();
        chk("refill_wb_rd", 32'(wb_rd), 3);
        chk("refill_wb_we", 32'(wb_reg_write), 1);

        // mul x3,x1,x2
        instr_d = I_MUL; valid_d = 1'b1;
        tick();
        valid_d = 1'b0;
`ifdef CTRL_MEXT_EN
        chk("mul_alu", 32'(ex_alu_ctrl), 16);
        chk("mul_illegal", 32'(ex_illegal), 0);
        tick(); tick();
        chk("mul_wb_we", 32'(wb_reg_write), 1);
`else
        chk("mul_illegal", 32'(ex_illegal), 1);
        chk("mul_alu", 32'(ex_alu_ctrl), 0);
        tick(); tick();
        chk("mul_wb_we", 32'(wb_reg_write), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
